opti_sos_sequencer: RTL and testbench
=====================================

# opti_sos_sequencer

Time-multiplexed controller and shared datapath for the 6-section SOS IIR cascade. It accepts one Q1.15 sample per handshake and walks one shared biquad through every section, one section per clock. It drives `stage_index` into the fixed-coefficient lookup and keeps the per-section delay state in internal registers. The filtered sample is returned on a valid/ready output port. It sits between the sample source (ADC/decimator) and the downstream consumer, wrapping the coefficient lookup.

## Interface
- `NUM_STAGES`, default 6: number of SOS sections sequenced (1–8).
- `DATA_W`, default 16: sample and coefficient width, two's complement.
- `COEF_FRAC`, default 13: coefficient fraction bits (Q2.13).
- `ACC_W`, default 36: width of the product sum and of each stored state word.

Ports:
- `clk` in 1: the only clock; all logic is rising-edge.
- `rst` in 1: reset, asynchronous and active-high.
- `in_valid` in 1: input sample valid.
- `in_ready` out 1: block can accept a sample.
- `in_data` in DATA_W: input sample, Q1.15.
- `out_valid` out 1: filtered sample valid.
- `out_ready` in 1: consumer accepts the output.
- `out_data` out DATA_W: filtered sample, Q1.15.
- `stage_index` out 3: section select to the coefficient lookup.
- `b0`, `b1`, `b2`, `a1`, `a2` in DATA_W each: coefficients for `stage_index`, combinational return from the lookup.
- `clear_state` in 1: synchronous zeroing of all section states; honoured only in IDLE.
- `busy` out 1: high in RUN or OUT.
- `sat_flag` out 1: sticky; set when any section output saturated.

## Operation
- FSM states are IDLE, RUN and OUT.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&`in_ready`: capture `in_data` into x_reg, set `stage_index`=0, go to RUN.
  - `clear_state` has priority over an input handshake in the same cycle. On that cycle: clear states and `sat_flag`, keep `in_ready`=0, accept no sample.
- RUN: each cycle computes section s=`stage_index` in direct form II transposed. Terms:
  - P0=b0·x, P1=b1·x, P2=b2·x, Q1=a1·y, Q2=a2·y.
  - Each product is full-precision signed and sign-extended to ACC_W.
  - Section output: y = sat(( P0 + s1[s] + 2^(COEF_FRAC-1) ) >>> COEF_FRAC), with arithmetic shift and round-half-up. sat clamps to [-32768, 32767]; any clamp sets `sat_flag`.
  - State update: s1[s] ← P1 − Q1 + s2[s]; s2[s] ← P2 − Q2. Both wrap modulo 2^ACC_W.
  - y replaces x_reg and feeds the next section.
  - If s = NUM_STAGES−1, register y into `out_data` and go to OUT. Otherwise `stage_index`++.
- OUT:
  - `out_valid`=1 and `out_data` held stable until `out_ready`. Then go to IDLE with `stage_index`=0.
  - No input is accepted in OUT (`in_ready`=0).
- `stage_index` holds 0 in IDLE and OUT. It never exceeds NUM_STAGES−1.

## Timing
- Reset values: `in_ready`=0 while `rst` is high, and 1 from the first edge after release. `out_valid`=0, `out_data`=0, `stage_index`=0, `busy`=0, `sat_flag`=0, all s1/s2=0, FSM=IDLE.
- Latency: input accepted at edge E. Sections are computed in the cycles following E … E+NUM_STAGES−1. `out_valid` rises after edge E+NUM_STAGES.
- Throughput:
  - With `out_ready` tied high, `out_valid` lasts 1 cycle and IDLE follows.
  - The next accept can happen at edge E+NUM_STAGES+2, so the minimum period is NUM_STAGES+2 cycles.
- Coefficients are sampled combinationally in the same cycle `stage_index` is presented. The lookup must be purely combinational.
- Backpressure: `out_ready` low holds OUT indefinitely. States are not touched.
- Reset asserted mid-RUN or mid-OUT has immediate effect: partial sample discarded, states zeroed, all outputs return to reset values.
- `in_valid` while `busy` is ignored. The source must hold the sample until `in_ready`.

## Test plan
- **Impulse, first section:** NUM_STAGES=1, section-0 coefficients (4088, 7325, 4088, 2842, 5981). Send `in_data`=16'h4000 → `out_data`=16'h1FF0 (8176). Then send 16'h0000 → 16'h2E26 (11814). `sat_flag`=0.
- **Full cascade against model:** NUM_STAGES=6, 200 random samples with random `out_ready` gaps → bit-exact match to a golden fixed-point model. `stage_index` reads 0,1,2,3,4,5 in consecutive RUN cycles for each sample.
- **Latency and idle behaviour:** accept at edge E → `out_valid` first seen after E+6 and `busy` high throughout. Zero input stream from reset → `out_data`=0 always.
- **Backpressure:** hold `out_ready`=0 for 10 cycles → `out_data` stable, `in_ready`=0, an asserted `in_valid` is not consumed, and the sample is accepted after the release.
- **Saturation:** stub coefficients b0=16'h7FFF, others 0, `in_data`=16'h7FFF → every section clamps, `out_data`=16'h7FFF and `sat_flag`=1. A following `clear_state` in IDLE → `sat_flag`=0 and states zero.
- **Reset mid-RUN:** assert `rst` at RUN section 3 → outputs are at reset values the same cycle. After release, an impulse reproduces the first-sample response of a fresh filter.

Source files
------------

// File: rtl/opti_sos_sequencer.sv
// opti_sos_sequencer: walks one shared direct-form-II-transposed biquad
// across NUM_STAGES cascaded sections, one section per clock, with
// valid/ready handshakes on the sample input and the filtered output.
module opti_sos_sequencer #(
  parameter int NUM_STAGES = 6,
  parameter int DATA_W     = 16,
  parameter int COEF_FRAC  = 13,
  parameter int ACC_W      = 36
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        stage_index,
  input  logic [DATA_W-1:0] b0,
  input  logic [DATA_W-1:0] b1,
  input  logic [DATA_W-1:0] b2,
  input  logic [DATA_W-1:0] a1,
  input  logic [DATA_W-1:0] a2,
  input  logic              clear_state,
  output logic              busy,
  output logic              sat_flag
);

  localparam int PROD_W = 2 * DATA_W;
  localparam logic [2:0] LAST_STAGE = 3'(NUM_STAGES - 1);
  localparam logic signed [ACC_W-1:0] ROUND_K = ACC_W'(1) << (COEF_FRAC - 1);
  localparam logic signed [ACC_W-1:0] Y_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Y_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

  state_t state_reg, state_next;
  logic [2:0] stage_reg, stage_next;
  logic ready_reg;
  logic sat_reg;
  logic signed [DATA_W-1:0] x_reg;
  logic [DATA_W-1:0] out_reg;

  logic do_accept, do_clear, do_step;

  // Per-section delay state, exposed as arrays for the shared datapath.
  logic signed [ACC_W-1:0] s1_arr [0:7];
  logic signed [ACC_W-1:0] s2_arr [0:7];

  logic signed [PROD_W-1:0] p0_full, p1_full, p2_full, q1_full, q2_full;
  logic signed [ACC_W-1:0]  p0, p1, p2, q1, q2;
  logic signed [ACC_W-1:0]  s1_cur, s2_cur, sum, shifted;
  logic signed [ACC_W-1:0]  s1_new, s2_new;
  logic signed [DATA_W-1:0] y;
  logic clip;

  // Shared biquad datapath for the section selected by stage_reg.
  always_comb begin
    s1_cur  = s1_arr[stage_reg];
    s2_cur  = s2_arr[stage_reg];
    p0_full = $signed(b0) * x_reg;
    p1_full = $signed(b1) * x_reg;
    p2_full = $signed(b2) * x_reg;
    p0      = {{(ACC_W-PROD_W){p0_full[PROD_W-1]}}, p0_full};
    p1      = {{(ACC_W-PROD_W){p1_full[PROD_W-1]}}, p1_full};
    p2      = {{(ACC_W-PROD_W){p2_full[PROD_W-1]}}, p2_full};
    sum     = p0 + s1_cur + ROUND_K;
    shifted = sum >>> COEF_FRAC;
    clip    = 1'b0;
    y       = shifted[DATA_W-1:0];
    if (shifted > Y_MAX) begin
      y    = Y_MAX[DATA_W-1:0];
      clip = 1'b1;
    end else if (shifted < Y_MIN) begin
      y    = Y_MIN[DATA_W-1:0];
      clip = 1'b1;
    end
    q1_full = $signed(a1) * y;
    q2_full = $signed(a2) * y;
    q1      = {{(ACC_W-PROD_W){q1_full[PROD_W-1]}}, q1_full};
    q2      = {{(ACC_W-PROD_W){q2_full[PROD_W-1]}}, q2_full};
    s1_new  = p1 - q1 + s2_cur;
    s2_new  = p2 - q2;
  end

  // Next-state and control strobes; clear_state beats a handshake in IDLE.
  always_comb begin
    state_next = state_reg;
    stage_next = stage_reg;
    do_accept  = 1'b0;
    do_clear   = 1'b0;
    do_step    = 1'b0;
    case (state_reg)
      IDLE: begin
        stage_next = 3'd0;
        if (clear_state) begin
          do_clear = 1'b1;
        end else if (in_valid && ready_reg) begin
          do_accept  = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        do_step = 1'b1;
        if (stage_reg == LAST_STAGE) begin
          state_next = OUT;
          stage_next = 3'd0;
        end else begin
          stage_next = stage_reg + 3'd1;
        end
      end
      OUT: begin
        stage_next = 3'd0;
        if (out_ready) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        stage_next = 3'd0;
      end
    endcase
  end

  // Control registers and sample/output datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      stage_reg <= 3'd0;
      ready_reg <= 1'b0;
      sat_reg   <= 1'b0;
      x_reg     <= '0;
      out_reg   <= '0;
    end else begin
      state_reg <= state_next;
      stage_reg <= stage_next;
      ready_reg <= 1'b1;
      if (do_clear) sat_reg <= 1'b0;
      else if (do_step && clip) sat_reg <= 1'b1;
      if (do_accept) x_reg <= in_data;
      else if (do_step) x_reg <= y;
      if (do_step && stage_reg == LAST_STAGE) out_reg <= y;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_stage
      if (gi < NUM_STAGES) begin : g_used
        logic signed [ACC_W-1:0] s1_q, s2_q;
        // Delay state of one section, written only while it is computed.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
          end else if (do_clear) begin
            s1_q <= '0;
            s2_q <= '0;
          end else if (do_step && stage_reg == 3'(gi)) begin
            s1_q <= s1_new;
            s2_q <= s2_new;
          end
        end
        assign s1_arr[gi] = s1_q;
        assign s2_arr[gi] = s2_q;
      end else begin : g_unused
        assign s1_arr[gi] = '0;
        assign s2_arr[gi] = '0;
      end
    end
  endgenerate

  assign in_ready    = ready_reg && (state_reg == IDLE) && !clear_state;
  assign out_valid   = (state_reg == OUT);
  assign out_data    = out_reg;
  assign stage_index = stage_reg;
  assign busy        = (state_reg != IDLE);
  assign sat_flag    = sat_reg;

endmodule

// File: tb/tb_opti_sos_sequencer.sv
// Bench for opti_sos_sequencer: a 6-section instance checked against a
// longint fixed-point cascade model, plus a 1-section impulse table.
module tb_opti_sos_sequencer;

  localparam int NS = 6;

  localparam int CB0 [NS] = '{4088, 3000, 5000, 2500, 6000, 4096};
  localparam int CB1 [NS] = '{7325, -2000, 8000, 1000, -6000, 0};
  localparam int CB2 [NS] = '{4088, 1500, 3000, -2500, 2000, 1024};
  localparam int CA1 [NS] = '{2842, -4000, 6000, -3000, 1000, 8000};
  localparam int CA2 [NS] = '{5981, 2000, 3000, 4000, -2000, 3000};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready, clear_state, busy, sat_flag;
  logic [15:0] in_data, out_data, b0, b1, b2, a1, a2;
  logic [2:0]  stage_index;
  logic        coef_mode;

  logic        in_valid1, in_ready1, out_valid1, busy1, sat_flag1;
  logic [15:0] in_data1, out_data1;
  logic [2:0]  stage_index1;

  opti_sos_sequencer #(.NUM_STAGES(NS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .stage_index(stage_index), .b0(b0), .b1(b1),
    .b2(b2), .a1(a1), .a2(a2), .clear_state(clear_state), .busy(busy),
    .sat_flag(sat_flag)
  );

  opti_sos_sequencer #(.NUM_STAGES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .out_valid(out_valid1), .out_ready(1'b1),
    .out_data(out_data1), .stage_index(stage_index1), .b0(16'd4088),
    .b1(16'd7325), .b2(16'd4088), .a1(16'd2842), .a2(16'd5981),
    .clear_state(1'b0), .busy(busy1), .sat_flag(sat_flag1)
  );

  // Combinational coefficient lookup for the 6-section instance.
  always_comb begin
    b0 = 16'd0; b1 = 16'd0; b2 = 16'd0; a1 = 16'd0; a2 = 16'd0;
    if (coef_mode) begin
      b0 = 16'h7FFF;
    end else if (int'(stage_index) < NS) begin
      b0 = 16'(CB0[stage_index]); b1 = 16'(CB1[stage_index]);
      b2 = 16'(CB2[stage_index]); a1 = 16'(CA1[stage_index]);
      a2 = 16'(CA2[stage_index]);
    end
  end

  int n_chk = 0;
  int n_fail = 0;
  int n_txn = 0;

  longint ms1 [NS];
  longint ms2 [NS];
  bit     msat;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint wrap36(input longint v);
    logic [63:0] u;
    u = v;
    u = {{28{u[35]}}, u[35:0]};
    return $signed(u);
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      ms1[s] = 0;
      ms2[s] = 0;
    end
    msat = 1'b0;
  endtask

  // Cascade of NS transposed direct-form II sections in plain arithmetic.
  function automatic logic [15:0] model_step(input logic [15:0] xin, input bit mode);
    longint x, y, t, c0, c1, c2, c3, c4;
    x = longint'($signed(xin));
    for (int s = 0; s < NS; s++) begin
      if (mode) begin
        c0 = 32767; c1 = 0; c2 = 0; c3 = 0; c4 = 0;
      end else begin
        c0 = CB0[s]; c1 = CB1[s]; c2 = CB2[s]; c3 = CA1[s]; c4 = CA2[s];
      end
      t = wrap36(c0 * x + ms1[s] + 4096) >>> 13;
      if (t > 32767) begin
        y = 32767; msat = 1'b1;
      end else if (t < -32768) begin
        y = -32768; msat = 1'b1;
      end else begin
        y = t;
      end
      ms1[s] = wrap36(c1 * x - c3 * y + ms2[s]);
      ms2[s] = wrap36(c2 * x - c4 * y);
      x = y;
    end
    return 16'(x);
  endfunction

  // One full transaction; starts and ends in the low clock phase.
  task automatic do_sample(input logic [15:0] x, input int gap);
    int wait_cnt;
    logic [15:0] exp, held;
    exp = model_step(x, coef_mode);
    out_ready = (gap == 0);
    in_data = x;
    in_valid = 1'b1;
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    chk("accept_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_data = ~x;
    for (int k = 0; k < NS; k++) begin
      @(negedge clk);
      chk("run_stage_index", stage_index, k);
      chk("run_busy", busy, 1);
      chk("run_out_valid", out_valid, 0);
      chk("run_in_ready", in_ready, 0);
    end
    @(negedge clk);
    chk("out_valid", out_valid, 1);
    chk("out_data", out_data, exp);
    chk("sat_flag", sat_flag, msat);
    held = out_data;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, held);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_stage_index", stage_index, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("idle_out_valid", out_valid, 0);
    chk("idle_busy", busy, 0);
    n_txn++;
    $display("txn %0d in=%h out=%h exp=%h gap=%0d sat=%0d", n_txn, x, held, exp, gap, sat_flag);
  endtask

  task automatic pulse_clear();
    clear_state = 1'b1;
    in_valid = 1'b1;
    in_data = 16'h5555;
    #1;
    chk("clear_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    clear_state = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("clear_no_accept", busy, 0);
    chk("clear_sat_flag", sat_flag, 0);
    $display("clear_state pulse sat=%0d busy=%0d", sat_flag, busy);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_stage_index"}, stage_index, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_sat_flag"}, sat_flag, 0);
  endtask

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
  } vec_t;

  vec_t tbl [3];

  initial begin
    int cnt;
    tbl[0] = '{x: 16'h4000, y: 16'h1FF0};
    tbl[1] = '{x: 16'h0000, y: 16'h2E26};
    tbl[2] = '{x: 16'h0000, y: 16'hF89C};

    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1; clear_state = 1'b0;
    coef_mode = 1'b0;
    in_valid1 = 1'b0; in_data1 = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_reset_values("reset");
    rst = 1'b0;
    #1;
    chk("ready_before_edge", in_ready, 0);
    @(negedge clk);
    chk("ready_after_edge", in_ready, 1);

    // Single-section impulse response table.
    for (int i = 0; i < 3; i++) begin
      in_valid1 = 1'b1;
      in_data1 = tbl[i].x;
      cnt = 0;
      while (!in_ready1 && cnt < 20) begin
        @(negedge clk);
        cnt++;
      end
      chk("n1_ready", in_ready1, 1);
      @(posedge clk);
      #1;
      in_valid1 = 1'b0;
      cnt = 0;
      @(negedge clk);
      while (!out_valid1 && cnt < 10) begin
        @(negedge clk);
        cnt++;
      end
      chk("n1_out_valid", out_valid1, 1);
      chk("n1_out_data", out_data1, tbl[i].y);
      $display("n1 vec %0d in=%h out=%h exp=%h", i, tbl[i].x, out_data1, tbl[i].y);
      @(negedge clk);
    end
    chk("n1_sat_flag", sat_flag1, 0);
    chk("n1_idle", {busy1, stage_index1}, 0);

    // Zero stream from reset must give zero output.
    for (int i = 0; i < 3; i++) do_sample(16'h0000, 0);
    chk("zero_out", out_data, 0);

    // Random cascade traffic with random output gaps.
    for (int i = 0; i < 200; i++)
      do_sample(16'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);

    // Long backpressure, then the following sample must still be accepted.
    do_sample(16'h2345, 10);
    do_sample(16'hC000, 0);

    // Saturation with stub coefficients, then clear.
    pulse_clear();
    model_reset();
    coef_mode = 1'b1;
    do_sample(16'h7FFF, 0);
    chk("sat_out_data", out_data, 16'h7FFF);
    chk("sat_flag_set", sat_flag, 1);
    coef_mode = 1'b0;
    pulse_clear();
    model_reset();
    do_sample(16'h4000, 0);

    // Reset while section 3 is being computed.
    in_valid = 1'b1;
    in_data = 16'h6000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cnt = 0;
    @(negedge clk);
    while (stage_index != 3'd3 && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    chk("midrun_stage", stage_index, 3);
    rst = 1'b1;
    #1;
    chk_reset_values("midrun");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    model_reset();
    do_sample(16'h4000, 0);
    do_sample(16'h0000, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
